// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: WB has priority, MDU results queue in a small FIFO,
// a starvation counter forces a one-cycle drain, and a pending scoreboard flags MDU hazards.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_wn,
    input  logic [31:0] wb_wdata,
    output logic        wb_hold,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_wn,
    input  logic [31:0] mdu_wdata,
    input  logic        issue_valid,
    input  logic [4:0]  issue_wn,
    output logic        issue_stall,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        rf_we,
    output logic [4:0]  rf_wn,
    output logic [31:0] rf_wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   PTR_ONE    = 1;
    localparam logic [SW-1:0] STARVE_ONE = 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {
        ARB,
        FORCE
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]    fifo_wn_q   [DEPTH];
    logic [4:0]    fifo_wn_d   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];
    logic [31:0]   pending_q, pending_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [SW-1:0] starve_inc;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_wn_q, rf_wn_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;

    logic        fifo_empty;
    logic        fifo_full;
    logic [4:0]  head_wn;
    logic [31:0] head_data;
    logic        wb_req;
    logic        push;
    logic        pop;
    logic        issue_set;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_wn    = fifo_wn_q[rd_ptr_q[AW-1:0]];
    assign head_data  = fifo_data_q[rd_ptr_q[AW-1:0]];

    assign mdu_ready   = rst && !fifo_full;
    assign push        = mdu_valid && mdu_ready && (mdu_wn != 5'd0);
    assign wb_req      = wb_valid && (wb_wn != 5'd0);
    assign wb_hold     = (state_q == FORCE);
    assign issue_stall = issue_valid && (issue_wn != 5'd0) && pending_q[issue_wn];
    assign issue_set   = issue_valid && (issue_wn != 5'd0) && !pending_q[issue_wn];
    assign rs_busy     = (rs != 5'd0) && pending_q[rs];
    assign rt_busy     = (rt != 5'd0) && pending_q[rt];
    assign starve_inc  = starve_q + STARVE_ONE;

    assign rf_we    = rf_we_q;
    assign rf_wn    = rf_wn_q;
    assign rf_wdata = rf_wdata_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_wn_d   = fifo_wn_q;
        fifo_data_d = fifo_data_q;
        pending_d   = pending_q;
        starve_d    = starve_q;
        rf_we_d     = 1'b0;
        rf_wn_d     = rf_wn_q;
        rf_wdata_d  = rf_wdata_q;
        pop         = 1'b0;

        case (state_q)
            ARB: begin
                if (wb_req) begin
                    rf_we_d    = 1'b1;
                    rf_wn_d    = wb_wn;
                    rf_wdata_d = wb_wdata;
                    if (fifo_empty) begin
                        starve_d = '0;
                    end else if (starve_inc == STARVE_MAX) begin
                        state_d  = FORCE;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_inc;
                    end
                end else begin
                    pop      = !fifo_empty;
                    starve_d = '0;
                end
            end
            FORCE: begin
                pop      = !fifo_empty;
                starve_d = '0;
                state_d  = ARB;
            end
            default: state_d = ARB;
        endcase

        if (pop) begin
            rf_we_d            = 1'b1;
            rf_wn_d            = head_wn;
            rf_wdata_d         = head_data;
            rd_ptr_d           = rd_ptr_q + PTR_ONE;
            pending_d[head_wn] = 1'b0;
        end

        if (push) begin
            fifo_wn_d[wr_ptr_q[AW-1:0]]   = mdu_wn;
            fifo_data_d[wr_ptr_q[AW-1:0]] = mdu_wdata;
            wr_ptr_d                      = wr_ptr_q + PTR_ONE;
        end

        // Issue is stalled while the bit is set, so set never collides with a clear.
        if (issue_set) begin
            pending_d[issue_wn] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ARB;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pending_q  <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_wn_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pending_q  <= pending_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_wn_q    <= rf_wn_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_wn_q   <= fifo_wn_d;
        fifo_data_q <= fifo_data_d;
    end

endmodule
